aidan_mcnay_iter_remainder: RTL and testbench
=============================================

// Module: aidan_mcnay_iter_remainder
// PURPOSE
//   Iterative restoring divider producing remainder and quotient, one bit per cycle.
//   Sits beside the prime-detector FSM control as its divide unit:
//   - FSM drives the istream with the candidate value and the trial divisor.
//   - FSM consumes ostream_remainder (zero = divides cleanly).
//   Latency-insensitive val/rdy on both sides; one operation in flight.
// PARAMETERS
//   nbits  16  operand / result width (dividend, divisor, quotient, remainder)
// PORTS
//   clk                input   1      clock, all state updates on posedge
//   reset              input   1      synchronous, active-low reset (0 = reset)
//   istream_val        input   1      request valid
//   istream_rdy        output  1      unit can accept a request
//   istream_dividend   input   nbits  dividend, unsigned
//   istream_divisor    input   nbits  divisor, unsigned
//   ostream_val        output  1      response valid
//   ostream_rdy        input   1      consumer accepts response
//   ostream_remainder  output  nbits  dividend mod divisor
//   ostream_quotient   output  nbits  dividend / divisor
// BEHAVIOUR
// States
//   - IDLE, CALC, DONE (2-bit encoding).
//   - reset==0 at a posedge -> IDLE, step counter 0, all datapath registers 0.
//   - After reset: istream_rdy=1, ostream_val=0, remainder=0, quotient=0.
// Handshake outputs
//   - istream_rdy = (state==IDLE), ostream_val = (state==DONE).
//   - Both are pure functions of state; no combinational in->out paths.
// Transitions
//   - IDLE & istream_val: latch dividend into quotient shift reg, divisor into divisor reg.
//     Clear the nbits+1-bit partial remainder, load counter = nbits, go to CALC.
//   - CALC, each cycle:
//     - P = {rem[nbits-1:0], q[nbits-1]}; q <<= 1.
//     - If P >= {1'b0,div}: rem = P - div, q[0]=1; else rem = P, q[0]=0.
//     - Decrement counter; when it reaches 0 at this edge, go to DONE.
//   - DONE & ostream_rdy -> IDLE. Otherwise hold DONE, outputs stable.
// Latency
//   - Accept edge E0 -> ostream_val high after edge E0+nbits (nbits CALC cycles).
//   - Min issue interval: nbits+2 cycles (accept, nbits CALC, DONE handshake).
//   - No accept in the same cycle as the DONE handshake.
// Ignored inputs
//   - istream_val and operands are ignored outside IDLE.
//   - Operands are sampled only on the accept edge.
// Outputs
//   - ostream_remainder = rem[nbits-1:0] and ostream_quotient = q, registered.
//   - Only meaningful while ostream_val=1.
// Boundary conditions
//   - Divisor 0: no special case. Algorithm yields quotient all-ones and remainder = dividend.
//   - dividend < divisor: quotient 0, remainder = dividend.
//   - dividend 0: quotient 0, remainder 0.
//   - Max operands handled without overflow (nbits+1-bit compare).
//   - Reset low in any state, including mid-CALC or DONE awaiting rdy:
//     abandon the operation, IDLE at that edge, no response produced.
// TESTING
//   - 17 / 5 (nbits=16): accept at E0; ostream_val rises after E0+16 -> rem 2, quot 3.
//   - 7 / 9 -> rem 7, quot 0.
//   - 0xFFFF / 0xFFFF -> rem 0, quot 1.
//   - 0x1234 / 0 -> rem 0x1234, quot 0xFFFF.
//   - Backpressure: ostream_rdy=0 for 5 cycles after val.
//     -> val and data held, istream_rdy stays 0.
//     -> rdy=1 -> IDLE, istream_rdy=1 next cycle.
//   - Reset mid-CALC: reset=0 at cycle 8 -> IDLE, ostream_val never asserts.
//     -> Next request 10/3 -> rem 1, quot 3.
//   - istream_val with new operands toggled throughout CALC -> ignored; result matches first request.

Source files
------------

// File: rtl/aidan_mcnay_iter_remainder.sv
// Iterative restoring divider: one quotient bit per CALC cycle, val/rdy on both sides.
module aidan_mcnay_iter_remainder #(
    parameter int unsigned nbits = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             istream_val,
    output logic             istream_rdy,
    input  logic [nbits-1:0] istream_dividend,
    input  logic [nbits-1:0] istream_divisor,
    output logic             ostream_val,
    input  logic             ostream_rdy,
    output logic [nbits-1:0] ostream_remainder,
    output logic [nbits-1:0] ostream_quotient
);

    localparam int unsigned CNT_W = $clog2(nbits + 1);
    localparam int unsigned P_W   = nbits + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    // The partial remainder is always below the divisor, so bit nbits of the
    // (nbits+1)-bit remainder is identically zero and is not stored.
    logic [nbits-1:0]   r_rem;
    logic [nbits-1:0]   r_q;
    logic [nbits-1:0]   r_div;
    logic [CNT_W-1:0]   r_cnt;

    logic [nbits-1:0]   w_rem_nxt;
    logic [nbits-1:0]   w_q_nxt;
    logic [nbits-1:0]   w_div_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;

    logic [P_W-1:0]     w_p;
    logic               w_ge;
    logic [nbits-1:0]   w_diff;

    // Shift the next dividend bit into the partial remainder and trial-subtract.
    assign w_p    = {r_rem, r_q[nbits-1]};
    assign w_ge   = (w_p >= {1'b0, r_div});
    assign w_diff = w_p[nbits-1:0] - r_div;

    // Handshake flags decode straight from the state register.
    assign istream_rdy       = (r_state == IDLE);
    assign ostream_val       = (r_state == DONE);
    assign ostream_remainder = r_rem;
    assign ostream_quotient  = r_q;

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_rem   <= '0;
            r_q     <= '0;
            r_div   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_q     <= w_q_nxt;
            r_div   <= w_div_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_q_nxt     = r_q;
        w_div_nxt   = r_div;
        w_cnt_nxt   = r_cnt;

        case (r_state)
            IDLE: begin
                if (istream_val) begin
                    w_q_nxt     = istream_dividend;
                    w_div_nxt   = istream_divisor;
                    w_rem_nxt   = '0;
                    w_cnt_nxt   = CNT_W'(nbits);
                    w_state_nxt = CALC;
                end
            end
            CALC: begin
                w_q_nxt   = {r_q[nbits-2:0], w_ge};
                w_rem_nxt = w_ge ? w_diff : w_p[nbits-1:0];
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (ostream_rdy) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_aidan_mcnay_iter_remainder.sv
// Directed bench for the iterative remainder/quotient divider.
`timescale 1ns/1ps
module tb_aidan_mcnay_iter_remainder;

    localparam int unsigned NB = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          istream_val;
    logic          istream_rdy;
    logic [NB-1:0] istream_dividend;
    logic [NB-1:0] istream_divisor;
    logic          ostream_val;
    logic          ostream_rdy;
    logic [NB-1:0] ostream_remainder;
    logic [NB-1:0] ostream_quotient;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [NB-1:0] dvd;
        logic [NB-1:0] dvs;
        logic [NB-1:0] rem;
        logic [NB-1:0] quo;
    } vec_t;

    vec_t vecs[10];

    aidan_mcnay_iter_remainder #(.nbits(NB)) dut (
        .clk               (clk),
        .reset             (reset),
        .istream_val       (istream_val),
        .istream_rdy       (istream_rdy),
        .istream_dividend  (istream_dividend),
        .istream_divisor   (istream_divisor),
        .ostream_val       (ostream_val),
        .ostream_rdy       (ostream_rdy),
        .ostream_remainder (ostream_remainder),
        .ostream_quotient  (ostream_quotient)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns just after the accept posedge.
    task automatic send(input logic [NB-1:0] a, input logic [NB-1:0] b);
        int t = 0;
        while (!istream_rdy && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("send_rdy", 32'(istream_rdy), 32'd1);
        istream_val      = 1'b1;
        istream_dividend = a;
        istream_divisor  = b;
        @(posedge clk);
        #1 istream_val = 1'b0;
    endtask

    // Counts posedges after accept until ostream_val is seen; ends at a negedge.
    task automatic wait_resp(input bit toggle, output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            if (toggle) begin
                #1;
                istream_val      = 1'($urandom_range(0, 1));
                istream_dividend = NB'($urandom);
                istream_divisor  = NB'($urandom);
            end
            @(negedge clk);
        end while (!ostream_val && lat < 100);
        istream_val = 1'b0;
        if (lat >= 100) check("resp_timeout", 32'(lat), 32'd0);
    endtask

    // Called at a negedge with ostream_val high; ends at a negedge.
    task automatic ack();
        ostream_rdy = 1'b1;
        @(posedge clk);
        #1 ostream_rdy = 1'b0;
        @(negedge clk);
        check("ack_in_rdy", 32'(istream_rdy), 32'd1);
        check("ack_out_val", 32'(ostream_val), 32'd0);
    endtask

    initial begin
        int lat;
        int seen;

        vecs[0] = '{16'd17,   16'd5,    16'd2,    16'd3};
        vecs[1] = '{16'd7,    16'd9,    16'd7,    16'd0};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 16'd0,    16'd1};
        vecs[3] = '{16'h1234, 16'd0,    16'h1234, 16'hFFFF};
        vecs[4] = '{16'd0,    16'd7,    16'd0,    16'd0};
        vecs[5] = '{16'd100,  16'd10,   16'd0,    16'd10};
        vecs[6] = '{16'hFFFF, 16'd1,    16'd0,    16'hFFFF};
        vecs[7] = '{16'd1000, 16'd7,    16'd6,    16'd142};
        vecs[8] = '{16'hFFFF, 16'h0100, 16'h00FF, 16'h00FF};
        vecs[9] = '{16'h8000, 16'd3,    16'd2,    16'd10922};

        reset            = 1'b0;
        istream_val      = 1'b0;
        istream_dividend = '0;
        istream_divisor  = '0;
        ostream_rdy      = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_rdy", 32'(istream_rdy), 32'd1);
        check("rst_out_val", 32'(ostream_val), 32'd0);
        check("rst_rem", 32'(ostream_remainder), 32'd0);
        check("rst_quo", 32'(ostream_quotient), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Table of single operations.
        for (int i = 0; i < 10; i++) begin
            send(vecs[i].dvd, vecs[i].dvs);
            check("busy_in_rdy", 32'(istream_rdy), 32'd0);
            wait_resp(1'b0, lat);
            check("latency", 32'(lat), 32'd16);
            check("vec_rem", 32'(ostream_remainder), 32'(vecs[i].rem));
            check("vec_quo", 32'(ostream_quotient), 32'(vecs[i].quo));
            ack();
        end

        // Backpressure: result held while consumer stalls.
        send(16'd17, 16'd5);
        wait_resp(1'b0, lat);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_val", 32'(ostream_val), 32'd1);
            check("bp_in_rdy", 32'(istream_rdy), 32'd0);
            check("bp_rem", 32'(ostream_remainder), 32'd2);
            check("bp_quo", 32'(ostream_quotient), 32'd3);
        end
        ack();

        // Reset mid-CALC abandons the operation.
        send(16'd50, 16'd7);
        repeat (7) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("midrst_in_rdy", 32'(istream_rdy), 32'd1);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ostream_val) seen++;
        end
        check("midrst_no_resp", 32'(seen), 32'd0);
        send(16'd10, 16'd3);
        wait_resp(1'b0, lat);
        check("after_rst_lat", 32'(lat), 32'd16);
        check("after_rst_rem", 32'(ostream_remainder), 32'd1);
        check("after_rst_quo", 32'(ostream_quotient), 32'd3);
        ack();

        // Reset while DONE waits for rdy drops the response.
        send(16'd1000, 16'd7);
        wait_resp(1'b0, lat);
        reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("donerst_val", 32'(ostream_val), 32'd0);
        check("donerst_in_rdy", 32'(istream_rdy), 32'd1);
        check("donerst_rem", 32'(ostream_remainder), 32'd0);

        // New requests during CALC are ignored.
        send(16'd1000, 16'd7);
        wait_resp(1'b1, lat);
        check("toggle_lat", 32'(lat), 32'd16);
        check("toggle_rem", 32'(ostream_remainder), 32'd6);
        check("toggle_quo", 32'(ostream_quotient), 32'd142);
        ack();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
